// File: rtl/alu_cmd_sequencer.sv
// Front-end for the byte-serial ALU: takes a parallel command, streams it onto
// INBUS after a start pulse, gathers result beats and returns one parallel response.
module alu_cmd_sequencer #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [7:0]  cmd_c,
  output logic [7:0]  alu_inbus,
  output logic        alu_start,
  input  logic [7:0]  alu_outbus,
  input  logic        alu_finish,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_GAP,
    S_SEND,
    S_WAIT_FIN,
    S_COLLECT,
    S_RESP
  } state_t;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_nxt;
  logic [1:0]       op_r;
  logic [7:0]       a_r, b_r, c_r, beat0_r;
  logic [1:0]       idx_r;
  logic [CNT_W-1:0] tmo_r;
  logic [1:0]       last_idx;
  logic             last_op, two_beats, tmo_hit;

  // mul returns {high, low}; div returns remainder first, quotient second
  function automatic logic [15:0] pack_two(input logic [1:0] op,
                                           input logic [7:0] b0,
                                           input logic [7:0] b1);
    return op[0] ? {b1, b0} : {b0, b1};
  endfunction

  assign last_idx  = (op_r == 2'd3) ? 2'd2 : 2'd1;
  assign last_op   = (idx_r == last_idx);
  assign two_beats = op_r[1];
  assign tmo_hit   = (tmo_r == TMO_LAST);

  assign cmd_ready = (state == S_IDLE);
  assign alu_start = (state == S_START);
  assign rsp_valid = (state == S_RESP);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (cmd_valid) state_nxt = S_START;
      S_START:    state_nxt = S_GAP;
      S_GAP:      state_nxt = S_SEND;
      S_SEND:     if (last_op) state_nxt = S_WAIT_FIN;
      // finish takes priority over a simultaneous timeout
      S_WAIT_FIN: begin
        if (alu_finish)   state_nxt = two_beats ? S_COLLECT : S_RESP;
        else if (tmo_hit) state_nxt = S_RESP;
      end
      S_COLLECT:  state_nxt = S_RESP;
      S_RESP:     if (rsp_ready) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx_r     <= '0;
      tmo_r     <= '0;
      alu_inbus <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            alu_inbus <= {6'b0, cmd_op};
            idx_r     <= '0;
          end
        end
        S_START: tmo_r <= '0;
        S_GAP:   alu_inbus <= a_r;
        S_SEND: begin
          if (!last_op) begin
            idx_r     <= idx_r + 2'd1;
            alu_inbus <= (idx_r == 2'd0) ? b_r : c_r;
          end
        end
        S_WAIT_FIN: begin
          tmo_r <= tmo_r + 1'b1;
          if (alu_finish) begin
            if (!two_beats) begin
              rsp_data <= {8'h00, alu_outbus};
              rsp_err  <= 1'b0;
            end
          end else if (tmo_hit) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end
        end
        S_COLLECT: begin
          rsp_data <= pack_two(op_r, beat0_r, alu_outbus);
          rsp_err  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // command and first-beat capture: pure data, no reset needed
  always_ff @(posedge clk) begin
    if (state == S_IDLE && cmd_valid) begin
      op_r <= cmd_op;
      a_r  <= cmd_a;
      b_r  <= cmd_b;
      c_r  <= cmd_c;
    end
    if (state == S_WAIT_FIN && alu_finish) beat0_r <= alu_outbus;
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: plays the ALU, checks the byte protocol cycle by
// cycle and compares responses against hand-computed and arithmetic expectations.
module tb_alu_cmd_sequencer;

  localparam int T = 255;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_a, cmd_b, cmd_c;
  logic [7:0]  alu_inbus;
  logic        alu_start;
  logic [7:0]  alu_outbus;
  logic        alu_finish;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_err;

  int n_cmp = 0;
  int n_mis = 0;

  alu_cmd_sequencer #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_c(cmd_c),
    .alu_inbus(alu_inbus), .alu_start(alu_start),
    .alu_outbus(alu_outbus), .alu_finish(alu_finish),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  a, b, c;
    int          fin;
    int          bp;
    bit          hold;
    logic [15:0] exp_d;
    logic        exp_e;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_rsp(input logic [1:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic [7:0] c);
    int dv, q, r;
    case (op)
      2'd0: return {8'h00, 8'((int'(a) + int'(b)) % 256)};
      2'd1: return {8'h00, 8'((int'(a) - int'(b) + 256) % 256)};
      2'd2: return 16'(int'(a) * int'(b));
      default: begin
        dv = int'(a) * 256 + int'(b);
        q  = dv / int'(c);
        r  = dv % int'(c);
        return {8'(q), 8'(r)};
      end
    endcase
  endfunction

  // One full transaction, entered and left just after a falling edge with DUT idle.
  task automatic do_txn(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input int fin_dly, input int bp,
                        input logic [15:0] exp_d, input logic exp_e, input bit stray,
                        input bit hold, input logic [1:0] nop, input logic [7:0] na,
                        input logic [7:0] nb, input logic [7:0] nc);
    logic [7:0]  ops [3];
    logic [7:0]  bt0, bt1;
    logic [15:0] prod;
    int          nops, nbeats, dv;
    ops    = '{a, b, c};
    nops   = (op == 2'd3) ? 3 : 2;
    nbeats = op[1] ? 2 : 1;
    bt1    = 8'h00;
    case (op)
      2'd0: bt0 = a + b;
      2'd1: bt0 = a - b;
      2'd2: begin prod = 16'(a) * 16'(b); bt0 = prod[15:8]; bt1 = prod[7:0]; end
      default: begin
        dv  = int'(a) * 256 + int'(b);
        bt0 = 8'(dv % int'(c));
        bt1 = 8'(dv / int'(c));
      end
    endcase

    chk("cmd_ready_idle", 32'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_c = c;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_c = 8'($urandom);
    chk("start_high", 32'(alu_start), 1);
    chk("start_inbus_op", 32'(alu_inbus), 32'({6'b0, op}));
    chk("cmd_ready_busy", 32'(cmd_ready), 0);
    alu_finish = stray; alu_outbus = 8'($urandom);
    @(negedge clk);
    alu_finish = 1'b0;
    chk("gap_start_low", 32'(alu_start), 0);
    chk("gap_inbus_op", 32'(alu_inbus), 32'({6'b0, op}));
    for (int i = 0; i < nops; i++) begin
      @(negedge clk);
      chk("send_inbus", 32'(alu_inbus), 32'(ops[i]));
      chk("send_start_low", 32'(alu_start), 0);
      alu_finish = stray ? 1'($urandom) : 1'b0;
      alu_outbus = 8'($urandom);
    end
    @(negedge clk);
    alu_finish = 1'b0;
    if (fin_dly >= 0 && fin_dly < T) begin
      for (int k = 0; k < fin_dly; k++) begin
        chk("wait_no_valid", 32'(rsp_valid), 0);
        @(negedge clk);
      end
      chk("wait_no_valid", 32'(rsp_valid), 0);
      chk("wait_inbus_hold", 32'(alu_inbus), 32'(ops[nops-1]));
      alu_finish = 1'b1; alu_outbus = bt0;
      @(negedge clk);
      alu_finish = 1'b0; alu_outbus = 8'($urandom);
      if (nbeats == 2) begin
        chk("collect_no_valid", 32'(rsp_valid), 0);
        alu_outbus = bt1;
        @(negedge clk);
        alu_outbus = 8'($urandom);
      end
    end else begin
      for (int k = 0; k < T; k++) begin
        chk("timeout_no_early_valid", 32'(rsp_valid), 0);
        @(negedge clk);
      end
    end

    chk("rsp_valid", 32'(rsp_valid), 1);
    chk("rsp_data", 32'(rsp_data), 32'(exp_d));
    chk("rsp_err", 32'(rsp_err), 32'(exp_e));
    chk("rsp_inbus_hold", 32'(alu_inbus), 32'(ops[nops-1]));
    rsp_ready = 1'b0;
    if (hold) begin
      cmd_valid = 1'b1; cmd_op = nop; cmd_a = na; cmd_b = nb; cmd_c = nc;
    end
    for (int j = 0; j < bp; j++) begin
      if (j == 0) begin alu_finish = 1'b1; alu_outbus = 8'($urandom); end
      @(negedge clk);
      alu_finish = 1'b0;
      chk("bp_valid", 32'(rsp_valid), 1);
      chk("bp_data_stable", 32'(rsp_data), 32'(exp_d));
      chk("bp_err_stable", 32'(rsp_err), 32'(exp_e));
      chk("bp_cmd_ready_low", 32'(cmd_ready), 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("after_rsp_idle_valid", 32'(rsp_valid), 0);
  endtask

  initial begin
    logic [1:0]  op;
    logic [7:0]  a, b, c;
    int          fin, bp;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_c = '0;
    alu_outbus = '0; alu_finish = 1'b0; rsp_ready = 1'b0;

    tbl[0] = '{2'd0, 8'd5,    8'd3,    8'd0,    0,     0, 1'b0, 16'h0008, 1'b0};
    tbl[1] = '{2'd2, 8'd23,   8'd4,    8'd0,    2,     1, 1'b0, 16'h005C, 1'b0};
    tbl[2] = '{2'd3, 8'h2D,   8'h16,   8'h87,   1,     0, 1'b0, 16'h5543, 1'b0};
    tbl[3] = '{2'd1, 8'd9,    8'd4,    8'd0,    -1,    0, 1'b0, 16'h0000, 1'b1};
    tbl[4] = '{2'd0, 8'h10,   8'h20,   8'd0,    3,     0, 1'b0, 16'h0030, 1'b0};
    tbl[5] = '{2'd1, 8'd3,    8'd5,    8'd0,    T - 1, 2, 1'b0, 16'h00FE, 1'b0};
    tbl[6] = '{2'd2, 8'hFF,   8'hFF,   8'd0,    0,     0, 1'b0, 16'hFE01, 1'b0};
    tbl[7] = '{2'd0, 8'hFF,   8'h01,   8'd0,    5,     0, 1'b0, 16'h0000, 1'b0};
    tbl[8] = '{2'd3, 8'h01,   8'h00,   8'h10,   0,     5, 1'b1, 16'h1000, 1'b0};
    tbl[9] = '{2'd0, 8'h07,   8'h08,   8'd0,    0,     0, 1'b0, 16'h000F, 1'b0};

    #12;
    chk("reset_cmd_ready", 32'(cmd_ready), 1);
    chk("reset_inbus", 32'(alu_inbus), 0);
    chk("reset_start", 32'(alu_start), 0);
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_rsp_data", 32'(rsp_data), 0);
    chk("reset_rsp_err", 32'(rsp_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      do_txn(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].fin, tbl[i].bp,
             tbl[i].exp_d, tbl[i].exp_e, 1'b0, tbl[i].hold,
             tbl[(i + 1) % 10].op, tbl[(i + 1) % 10].a, tbl[(i + 1) % 10].b,
             tbl[(i + 1) % 10].c);
    end

    // reset while a divide is streaming its operands
    cmd_valid = 1'b1; cmd_op = 2'd3; cmd_a = 8'h11; cmd_b = 8'h22; cmd_c = 8'h33;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midreset_send_inbus", 32'(alu_inbus), 32'h11);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_cmd_ready", 32'(cmd_ready), 1);
    chk("midreset_inbus", 32'(alu_inbus), 0);
    chk("midreset_start", 32'(alu_start), 0);
    chk("midreset_rsp_valid", 32'(rsp_valid), 0);
    chk("midreset_rsp_data", 32'(rsp_data), 0);
    chk("midreset_rsp_err", 32'(rsp_err), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    alu_finish = 1'b1; alu_outbus = 8'hA5;
    @(negedge clk);
    alu_finish = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("post_reset_no_valid", 32'(rsp_valid), 0);
      chk("post_reset_idle", 32'(cmd_ready), 1);
      @(negedge clk);
    end
    do_txn(2'd0, 8'd40, 8'd2, 8'd0, 1, 0, 16'h002A, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 8'd0);

    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom);
      a  = 8'($urandom);
      b  = 8'($urandom);
      c  = 8'($urandom);
      if (op == 2'd3) begin
        if (a == 8'hFF) a = 8'hFE;
        c = 8'($urandom_range(255, int'(a) + 1));
      end
      fin = ($urandom_range(0, 19) == 0) ? -1 : int'($urandom_range(0, 6));
      bp  = int'($urandom_range(0, 3));
      if (fin < 0)
        do_txn(op, a, b, c, fin, bp, 16'h0000, 1'b1, 1'($urandom), 1'b0, 2'd0, 8'd0, 8'd0, 8'd0);
      else
        do_txn(op, a, b, c, fin, bp, ref_rsp(op, a, b, c), 1'b0, 1'($urandom), 1'b0,
               2'd0, 8'd0, 8'd0, 8'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
